// File: rtl/arcade_input_pkg.sv
// Shared constants for the arcade input decoder: PS/2 scan codes, key latch
// slots, output bit positions, joystick bit positions and the coin FSM states.
package arcade_input_pkg;

  localparam logic [7:0] SC_UP       = 8'h75;
  localparam logic [7:0] SC_DOWN     = 8'h72;
  localparam logic [7:0] SC_LEFT     = 8'h6B;
  localparam logic [7:0] SC_RIGHT    = 8'h74;
  localparam logic [7:0] SC_SPACE    = 8'h29;
  localparam logic [7:0] SC_CTRL     = 8'h14;
  localparam logic [7:0] SC_F1       = 8'h05;
  localparam logic [7:0] SC_F2       = 8'h06;
  localparam logic [7:0] SC_START1   = 8'h16;
  localparam logic [7:0] SC_START2   = 8'h1E;
  localparam logic [7:0] SC_COIN1    = 8'h2E;
  localparam logic [7:0] SC_COIN2    = 8'h36;
  localparam logic [7:0] SC_P2_UP    = 8'h2D;
  localparam logic [7:0] SC_P2_DOWN  = 8'h2B;
  localparam logic [7:0] SC_P2_LEFT  = 8'h23;
  localparam logic [7:0] SC_P2_RIGHT = 8'h34;
  localparam logic [7:0] SC_P2_FIREA = 8'h1C;
  localparam logic [7:0] SC_P2_FIREB = 8'h1B;

  // One latch per physical key so overlapping presses release independently.
  localparam int K_UP1 = 0,  K_DN1 = 1,  K_LT1 = 2,  K_RT1 = 3;
  localparam int K_SPC = 4,  K_CTL = 5,  K_F1  = 6,  K_F2  = 7;
  localparam int K_S1  = 8,  K_S2  = 9,  K_C1  = 10, K_C2  = 11;
  localparam int K_UP2 = 12, K_DN2 = 13, K_LT2 = 14, K_RT2 = 15;
  localparam int K_FA2 = 16, K_FB2 = 17;
  localparam int NUM_KEYS = 18;

  localparam int I0_TRIG1 = 0, I0_TRIG2 = 1, I0_START1 = 2, I0_START2 = 3;
  localparam int I0_COIN1 = 4, I0_COIN2 = 5, I0_SERVICE = 7;
  localparam int I1_UP1 = 0, I1_RIGHT1 = 1, I1_DOWN1 = 2, I1_LEFT1 = 3;
  localparam int I1_UP2 = 4, I1_RIGHT2 = 5, I1_DOWN2 = 6, I1_LEFT2 = 7;

  localparam int J_RIGHT = 0, J_LEFT = 1, J_DOWN = 2, J_UP = 3;
  localparam int J_FIRE = 4, J_START1 = 5, J_START2 = 6, J_COIN = 7;

  typedef enum logic [1:0] {
    COIN_IDLE  = 2'd0,
    COIN_PULSE = 2'd1,
    COIN_HOLD  = 2'd2
  } coin_state_e;

endpackage

// File: rtl/arcade_input_decoder_coin_pulse.sv
// Coin pulse stretcher: one raw-coin rising edge yields a pulse FRAMES vblanks
// long; the coin must be released before it can trigger again.
module coin_pulse
  import arcade_input_pkg::*;
#(
  parameter int FRAMES = 4
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic coin_raw_i,
  input  logic vb_rise_i,
  output logic pulse_o
);

  localparam logic [3:0] LAST = 4'(FRAMES);

  coin_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        raw_q;

  // A release during PULSE is ignored; HOLD picks it up once counting is done.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      COIN_IDLE: if (coin_raw_i && !raw_q) begin
        state_d = COIN_PULSE;
        cnt_d   = '0;
      end
      COIN_PULSE: if (vb_rise_i) begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_d == LAST) state_d = COIN_HOLD;
      end
      COIN_HOLD: if (!coin_raw_i) state_d = COIN_IDLE;
      default: state_d = COIN_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= COIN_IDLE;
      cnt_q   <= '0;
      raw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      raw_q   <= coin_raw_i;
    end
  end

  assign pulse_o = (state_q == COIN_PULSE);

endmodule

// File: rtl/arcade_input_decoder.sv
// PS/2 keyboard + two joysticks to arcade inp0/inp1 ports with coin pulses.
// Define KEYB_P2_EN to decode the player-2 / JPAC keyboard codes.
module arcade_input_decoder
  import arcade_input_pkg::*;
#(
  parameter int COIN_FRAMES = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystk1,
  input  logic [15:0] joystk2,
  input  logic        vblank,
  input  logic        cabinet,
  input  logic        service,
  output logic [7:0]  inp0,
  output logic [7:0]  inp1
);

  logic                toggle_q, armed_q, vblank_q;
  logic [NUM_KEYS-1:0] key_q, key_d;
  logic [4:0]          ctl_q, ctl_d;
  logic [7:0]          inp1_q, inp1_d;
  logic                key_evt, pressed, ext, vb_rise;
  logic [7:0]          code;
  logic                up1, dn1, lt1, rt1, fire1, up2, dn2, lt2, rt2, fire2;
  logic                start1, start2, coin1_raw, coin2_raw, coin1, coin2;
  logic                unused_joy;

  assign unused_joy = ^{joystk1[15:8], joystk2[15:8]};
  assign pressed    = ps2_key[9];
  assign ext        = ps2_key[8];
  assign code       = ps2_key[7:0];
  // armed_q stays low for the first cycle after reset so a stale toggle is absorbed.
  assign key_evt    = armed_q && (ps2_key[10] != toggle_q);
  assign vb_rise    = vblank && !vblank_q;

  always_comb begin
    key_d = key_q;
    if (key_evt) begin
      case (code)
        SC_UP:    key_d[K_UP1] = pressed;
        SC_DOWN:  key_d[K_DN1] = pressed;
        SC_LEFT:  key_d[K_LT1] = pressed;
        SC_RIGHT: key_d[K_RT1] = pressed;
        default: ;
      endcase
      if (!ext) begin
        case (code)
          SC_SPACE:    key_d[K_SPC] = pressed;
          SC_CTRL:     key_d[K_CTL] = pressed;
          SC_F1:       key_d[K_F1]  = pressed;
          SC_F2:       key_d[K_F2]  = pressed;
          SC_START1:   key_d[K_S1]  = pressed;
          SC_START2:   key_d[K_S2]  = pressed;
          SC_COIN1:    key_d[K_C1]  = pressed;
`ifdef KEYB_P2_EN
          SC_COIN2:    key_d[K_C2]  = pressed;
          SC_P2_UP:    key_d[K_UP2] = pressed;
          SC_P2_DOWN:  key_d[K_DN2] = pressed;
          SC_P2_LEFT:  key_d[K_LT2] = pressed;
          SC_P2_RIGHT: key_d[K_RT2] = pressed;
          SC_P2_FIREA: key_d[K_FA2] = pressed;
          SC_P2_FIREB: key_d[K_FB2] = pressed;
`endif
          default: ;
        endcase
      end
    end
  end

  // Upright cabinets share one control panel, so P2 also drives P1.
  assign up2   = key_q[K_UP2] | joystk2[J_UP];
  assign dn2   = key_q[K_DN2] | joystk2[J_DOWN];
  assign lt2   = key_q[K_LT2] | joystk2[J_LEFT];
  assign rt2   = key_q[K_RT2] | joystk2[J_RIGHT];
  assign fire2 = key_q[K_FA2] | key_q[K_FB2] | joystk2[J_FIRE];
  assign up1   = key_q[K_UP1] | joystk1[J_UP]    | (!cabinet & up2);
  assign dn1   = key_q[K_DN1] | joystk1[J_DOWN]  | (!cabinet & dn2);
  assign lt1   = key_q[K_LT1] | joystk1[J_LEFT]  | (!cabinet & lt2);
  assign rt1   = key_q[K_RT1] | joystk1[J_RIGHT] | (!cabinet & rt2);
  assign fire1 = key_q[K_SPC] | key_q[K_CTL] | joystk1[J_FIRE] | (!cabinet & fire2);

  assign start1    = key_q[K_F1] | key_q[K_S1] | joystk1[J_START1] | joystk2[J_START1];
  assign start2    = key_q[K_F2] | key_q[K_S2] | joystk1[J_START2] | joystk2[J_START2];
  assign coin1_raw = key_q[K_F1] | key_q[K_C1] | joystk1[J_COIN];
  assign coin2_raw = key_q[K_F2] | key_q[K_C2] | joystk2[J_COIN];

  assign ctl_d  = {service, start2, start1, fire2, fire1};
  assign inp1_d = {lt2, dn2, rt2, up2, lt1, dn1, rt1, up1};

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      toggle_q <= 1'b0;
      armed_q  <= 1'b0;
      vblank_q <= 1'b0;
      key_q    <= '0;
      ctl_q    <= '0;
      inp1_q   <= '0;
    end else begin
      toggle_q <= ps2_key[10];
      armed_q  <= 1'b1;
      vblank_q <= vblank;
      key_q    <= key_d;
      ctl_q    <= ctl_d;
      inp1_q   <= inp1_d;
    end
  end

  coin_pulse #(.FRAMES(COIN_FRAMES)) u_coin1 (
    .clk_sys(clk_sys), .reset_n(reset_n), .coin_raw_i(coin1_raw),
    .vb_rise_i(vb_rise), .pulse_o(coin1)
  );

  coin_pulse #(.FRAMES(COIN_FRAMES)) u_coin2 (
    .clk_sys(clk_sys), .reset_n(reset_n), .coin_raw_i(coin2_raw),
    .vb_rise_i(vb_rise), .pulse_o(coin2)
  );

  // Coin bits come straight from the FSM state register so reset clears them at once.
  assign inp0 = {ctl_q[4], 1'b0, coin2, coin1, ctl_q[3:0]};
  assign inp1 = inp1_q;

endmodule

// File: doc/arcade_input_decoder.md
ARCADE_INPUT_DECODER -- requirements
Module: arcade_input_decoder

Interface
REQ-001 The module SHALL have parameter COIN_FRAMES, default 4, meaning the number of frames a coin output is held high per insertion (range 1..15).
REQ-002 The module SHALL have port clk_sys, input, 1 bit: the single system clock; all logic SHALL be on its rising edge.
REQ-003 The module SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port ps2_key, input, 11 bits: [10] event toggle, [9] pressed, [8] extended flag, [7:0] scan code.
REQ-005 The module SHALL have ports joystk1 and joystk2, input, 16 bits each: [0] right, [1] left, [2] down, [3] up, [4] fire, [5] start1, [6] start2, [7] coin.
REQ-006 The module SHALL have port vblank, input, 1 bit: the frame tick source; its rising edge counts as one frame.
REQ-007 The module SHALL have port cabinet, input, 1 bit: 0 selects upright (P2 controls merged into P1), 1 selects cocktail.
REQ-008 The module SHALL have port service, input, 1 bit: the service-mode switch.
REQ-009 The module SHALL have port inp0, output, 8 bits: {service, 0, coin2, coin1, start2, start1, trig2, trig1}.
REQ-010 The module SHALL have port inp1, output, 8 bits: {left2, down2, right2, up2, left1, down1, right1, up1}.

Function
REQ-011 A key event SHALL be the cycle on which ps2_key[10] differs from its value registered on the previous cycle.
REQ-012 On a key event, the latch selected by the code SHALL be loaded with ps2_key[9]; unlisted codes SHALL be ignored.
REQ-013 Arrow keys 75/72/6B/74 SHALL map to P1 up/down/left/right, ignoring [8].
REQ-014 All other codes SHALL require [8]=0, mapped as: 29 space and 14 ctrl to P1 fire; 05 F1 to start1 and coin1; 06 F2 to start2 and coin2; 16 to start1; 1E to start2; 2E to coin1; 36 to coin2; 2D/2B/23/34 to P2 up/down/left/right; 1C and 1B to P2 fire.
REQ-015 Each physical key SHALL have its own latch, and a function's key contribution SHALL be the OR of its latches, so that releasing one key does not clear another held key.
REQ-016 Raw P1 direction/fire SHALL be key | joystk1 | (cabinet ? 0 : corresponding P2 raw); raw P2 SHALL be key | joystk2.
REQ-017 start1/start2 SHALL be the keys OR joystk1[5|6] OR joystk2[5|6]; raw coin1 SHALL be keys | joystk1[7]; raw coin2 SHALL be keys | joystk2[7].
REQ-018 inp0 and inp1 SHALL be registered: a key event on cycle N SHALL appear at the outputs after edge N+2, and a joystick change after edge N+1.
REQ-019 Each coin SHALL use a three-state machine: IDLE, PULSE and HOLD.
REQ-020 In IDLE, a raw-coin rising edge SHALL move to PULSE, clear the frame counter and drive the coin output high.
REQ-021 In PULSE, each vblank rising edge SHALL increment the counter; at COIN_FRAMES it SHALL go to HOLD with output low.
REQ-022 In HOLD, the output SHALL stay low until raw coin is low, then go to IDLE; a held coin SHALL never re-trigger.
REQ-023 When a raw-coin release and a vblank edge fall on the same cycle in PULSE, counting SHALL take precedence and the pulse SHALL not be shortened.
REQ-024 The two coin channels SHALL be independent; simultaneous insertion SHALL produce two concurrent pulses.

Reset
REQ-025 While reset_n is low, all latches, inp0, inp1, counters and registered toggle SHALL be 0, and coin FSMs SHALL be in IDLE.
REQ-026 On the first cycle after reset release, the toggle SHALL only be captured, with no event decoded, so a stale toggle=1 never creates a phantom press.
REQ-027 Reset asserted mid-pulse SHALL force the coin output low immediately (asynchronously).

Configuration
REQ-028 With macro KEYB_P2_EN defined, the P2/JPAC codes 2D, 2B, 23, 34, 1C, 1B and 36 SHALL be decoded; without it, those codes SHALL be ignored, and P2 and coin2 SHALL come only from joystk2 and F2.

Structure
REQ-029 Package arcade_input_pkg SHALL hold the scan-code constants, the coin-state enum, the inp0/inp1 bit-index constants and the joystick bit indices.
REQ-030 Sub-module coin_pulse (the FSM and counter) SHALL be instantiated once per coin.

Verification
REQ-031 A bench SHALL apply toggle with code 029 pressed, then 014 pressed, then 014 released, and SHALL check inp0[0]=1 throughout, then 0 after 029 is released.
REQ-032 A bench SHALL apply reset release with ps2_key=11'h429 and SHALL check inp0=8'h00 and inp1=8'h00 with no event.
REQ-033 A bench SHALL press 2E for 10 frames with COIN_FRAMES=4, and SHALL check inp0[4] high for exactly 4 vblank edges, then low, with no second pulse until release and re-press.
REQ-034 A bench SHALL set joystk2[3]=1 with cabinet=0, and SHALL check inp1=8'h11; with cabinet=1, it SHALL check inp1=8'h10.
REQ-035 A bench SHALL assert reset_n low during a coin pulse, and SHALL check inp0[5:4]=0 immediately and the FSM in IDLE after release.
REQ-036 A bench SHALL send code 02D without KEYB_P2_EN and SHALL check inp1=8'h00; with the macro defined, it SHALL check inp1[4]=1 two cycles after the event.
